// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: PRGA state encoding, default message length and
// the plaintext character class used by the key search.
package rc4_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_READ_I,
        ST_WAIT_I,
        ST_READ_J,
        ST_WAIT_J,
        ST_WRITE_I,
        ST_WRITE_J,
        ST_READ_F,
        ST_WAIT_F,
        ST_WRITE_D,
        ST_DONE
    } rc4_state_t;

    localparam int         MSG_LEN_DEFAULT = 32;
    localparam logic [7:0] CHAR_LO         = 8'h61;
    localparam logic [7:0] CHAR_HI         = 8'h7A;
    localparam logic [7:0] CHAR_SPACE      = 8'h20;

endpackage

// File: rtl/rc4_char_check.sv
// Combinational plaintext character classifier: legal = 'a'..'z' or space.
module rc4_char_check
    import rc4_pkg::*;
(
    input  logic [7:0] byte_val,
    output logic       legal
);

    assign legal = ((byte_val >= CHAR_LO) && (byte_val <= CHAR_HI)) ||
                   (byte_val == CHAR_SPACE);

endmodule

// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream generation and decryption: permutes S, writes D = keystream ^ E,
// and aborts with key_valid=0 at the first plaintext byte outside the legal set.
module rc4_prga_decrypt
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = MSG_LEN_DEFAULT,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              done,
    output logic              key_valid,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic              s_wren,
    input  logic [DATA_W-1:0] s_rdata,
    output logic [ADDR_W-1:0] e_addr,
    input  logic [DATA_W-1:0] e_rdata,
    output logic [ADDR_W-1:0] d_addr,
    output logic [DATA_W-1:0] d_wdata,
    output logic              d_wren
);

    rc4_state_t        state_r, state_s;
    logic [ADDR_W-1:0] i_r, j_r, k_r, i_s, j_s, k_s;
    logic [DATA_W-1:0] si_r, sj_r, f_r, e_byte_r;
    logic [DATA_W-1:0] si_s, sj_s, f_s, e_byte_s;
    logic              key_valid_s;
    logic [ADDR_W-1:0] s_addr_s, e_addr_s, d_addr_s;
    logic [DATA_W-1:0] s_wdata_s, d_wdata_s;
    logic              s_wren_s, d_wren_s, done_s;
    logic [DATA_W-1:0] plain_s;
    logic              legal_s;

    assign plain_s = f_r ^ e_byte_r;

    rc4_char_check u_char_check (
        .byte_val (8'(plain_s)),
        .legal    (legal_s)
    );

    // Next-state and working-register update, one algorithm step per state.
    always_comb begin
        state_s     = state_r;
        i_s         = i_r;
        j_s         = j_r;
        k_s         = k_r;
        si_s        = si_r;
        sj_s        = sj_r;
        f_s         = f_r;
        e_byte_s    = e_byte_r;
        key_valid_s = key_valid;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    i_s         = '0;
                    j_s         = '0;
                    k_s         = '0;
                    key_valid_s = 1'b0;
                    state_s     = ST_READ_I;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ_I: begin
                i_s     = i_r + ADDR_W'(1'b1);
                state_s = ST_WAIT_I;
            end
            ST_WAIT_I: begin
                si_s    = s_rdata;
                j_s     = j_r + ADDR_W'(s_rdata);
                state_s = ST_READ_J;
            end
            ST_READ_J:  state_s = ST_WAIT_J;
            ST_WAIT_J: begin
                sj_s    = s_rdata;
                state_s = ST_WRITE_I;
            end
            ST_WRITE_I: state_s = ST_WRITE_J;
            ST_WRITE_J: state_s = ST_READ_F;
            ST_READ_F:  state_s = ST_WAIT_F;
            ST_WAIT_F: begin
                f_s      = s_rdata;
                e_byte_s = e_rdata;
                state_s  = ST_WRITE_D;
            end
            ST_WRITE_D: begin
                if (!legal_s) begin
                    key_valid_s = 1'b0;
                    state_s     = ST_DONE;
                end else if (k_r == ADDR_W'(MSG_LEN - 1)) begin
                    key_valid_s = 1'b1;
                    state_s     = ST_DONE;
                end else begin
                    k_s     = k_r + ADDR_W'(1'b1);
                    state_s = ST_READ_I;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Memory-port values for the state being entered, so they register cleanly.
    always_comb begin
        s_addr_s  = '0;
        s_wdata_s = '0;
        s_wren_s  = 1'b0;
        e_addr_s  = '0;
        d_addr_s  = '0;
        d_wdata_s = '0;
        d_wren_s  = 1'b0;
        done_s    = 1'b0;
        case (state_s)
            ST_READ_I:  s_addr_s = i_s + ADDR_W'(1'b1);
            ST_READ_J:  s_addr_s = j_s;
            ST_WRITE_I: begin
                s_addr_s  = i_s;
                s_wdata_s = sj_s;
                s_wren_s  = 1'b1;
            end
            ST_WRITE_J: begin
                s_addr_s  = j_s;
                s_wdata_s = si_s;
                s_wren_s  = 1'b1;
            end
            ST_READ_F: begin
                s_addr_s = ADDR_W'(si_s + sj_s);
                e_addr_s = k_s;
            end
            ST_WRITE_D: begin
                d_addr_s  = k_s;
                d_wdata_s = f_s ^ e_byte_s;
                d_wren_s  = 1'b1;
            end
            ST_DONE:    done_s = 1'b1;
            default:    done_s = 1'b0;
        endcase
    end

    // State, working registers and registered memory ports.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            i_r       <= '0;
            j_r       <= '0;
            k_r       <= '0;
            si_r      <= '0;
            sj_r      <= '0;
            f_r       <= '0;
            e_byte_r  <= '0;
            key_valid <= 1'b0;
            done      <= 1'b0;
            s_addr    <= '0;
            s_wdata   <= '0;
            s_wren    <= 1'b0;
            e_addr    <= '0;
            d_addr    <= '0;
            d_wdata   <= '0;
            d_wren    <= 1'b0;
        end else begin
            state_r   <= state_s;
            i_r       <= i_s;
            j_r       <= j_s;
            k_r       <= k_s;
            si_r      <= si_s;
            sj_r      <= sj_s;
            f_r       <= f_s;
            e_byte_r  <= e_byte_s;
            key_valid <= key_valid_s;
            done      <= done_s;
            s_addr    <= s_addr_s;
            s_wdata   <= s_wdata_s;
            s_wren    <= s_wren_s;
            e_addr    <= e_addr_s;
            d_addr    <= d_addr_s;
            d_wdata   <= d_wdata_s;
            d_wren    <= d_wren_s;
        end
    end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Self-checking bench for rc4_prga_decrypt: bench-side memories, a plain RC4
// reference model, hand-computed pins and randomized permutations/ciphertext.
module tb_rc4_prga_decrypt;

    localparam int MSG_LEN = 32;

    logic       clk = 1'b0;
    logic       reset_n, start;
    logic       done, key_valid;
    logic [7:0] s_addr, s_wdata, s_rdata, e_addr, e_rdata, d_addr, d_wdata;
    logic       s_wren, d_wren;

    logic       ld_s, ld_e;
    logic [7:0] ld_addr, ld_sdata, ld_edata;
    logic [7:0] s_mem [256];
    logic [7:0] e_mem [256];
    logic [7:0] d_mem [256];

    int ref_s [256];
    int ref_e [256];
    int exp_d [$];
    int exp_kv;
    int n_pass = 0;
    int n_checks = 0;
    int wr_idx = 0;
    bit run_active = 1'b0;

    rc4_prga_decrypt #(.MSG_LEN(MSG_LEN), .ADDR_W(8), .DATA_W(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .done      (done),
        .key_valid (key_valid),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_wren    (s_wren),
        .s_rdata   (s_rdata),
        .e_addr    (e_addr),
        .e_rdata   (e_rdata),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wren    (d_wren)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories with a bench-side loader port.
    always @(posedge clk) begin
        s_rdata <= s_mem[s_addr];
        e_rdata <= e_mem[e_addr];
        if (ld_s) s_mem[ld_addr] <= ld_sdata;
        else if (s_wren) s_mem[s_addr] <= s_wdata;
        if (ld_e) e_mem[ld_addr] <= ld_edata;
        if (d_wren) d_mem[d_addr] <= d_wdata;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    function automatic bit is_legal(input int p);
        return ((p >= 97) && (p <= 122)) || (p == 32);
    endfunction

    // Plain RC4 PRGA over ref_s/ref_e; stops after the first illegal byte.
    task automatic model_run();
        int i, j, si, sj, p;
        i = 0; j = 0;
        exp_d.delete();
        exp_kv = 1;
        for (int k = 0; k < MSG_LEN; k++) begin
            i = (i + 1) % 256;
            si = ref_s[i];
            j = (j + si) % 256;
            sj = ref_s[j];
            ref_s[i] = sj;
            ref_s[j] = si;
            p = ref_s[(si + sj) % 256] ^ ref_e[k];
            exp_d.push_back(p);
            if (!is_legal(p)) begin
                exp_kv = 0;
                break;
            end
        end
    endtask

    task automatic set_identity();
        for (int x = 0; x < 256; x++) begin
            ref_s[x] = x;
            ref_e[x] = 0;
        end
    endtask

    task automatic rand_perm();
        int r, t;
        set_identity();
        for (int x = 255; x > 0; x--) begin
            r = int'($urandom_range(0, x));
            t = ref_s[x]; ref_s[x] = ref_s[r]; ref_s[r] = t;
        end
    endtask

    // Ciphertext that decrypts to random legal text over the current ref_s.
    task automatic gen_legal_e();
        int t [256];
        int i, j, si, sj, r;
        i = 0; j = 0;
        for (int x = 0; x < 256; x++) t[x] = ref_s[x];
        for (int k = 0; k < MSG_LEN; k++) begin
            i = (i + 1) % 256;
            si = t[i];
            j = (j + si) % 256;
            sj = t[j];
            t[i] = sj; t[j] = si;
            r = int'($urandom_range(0, 26));
            ref_e[k] = t[(si + sj) % 256] ^ ((r == 26) ? 32 : 97 + r);
        end
    endtask

    task automatic load_mem();
        for (int x = 0; x < 256; x++) begin
            @(negedge clk);
            ld_s = 1'b1;
            ld_e = 1'b1;
            ld_addr = 8'(x);
            ld_sdata = 8'(ref_s[x]);
            ld_edata = 8'(ref_e[x]);
        end
        @(negedge clk);
        ld_s = 1'b0;
        ld_e = 1'b0;
    endtask

    // Raise start and count edges until done; start is left high.
    task automatic do_run(output int lat, output int nwr);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        run_active = 1'b1;
        lat = 1;
        forever begin
            @(negedge clk);
            if (done) break;
            if (lat >= 9 * MSG_LEN + 20) begin
                chk("done_timeout", 32'(lat), 32'(9 * MSG_LEN + 1));
                break;
            end
            @(posedge clk);
            lat++;
        end
        nwr = wr_idx;
        run_active = 1'b0;
    endtask

    task automatic end_run();
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_run(input string tag, input int lat, input int nwr);
        int mism;
        mism = 0;
        chk({tag, "_latency"}, 32'(lat), 32'(9 * exp_d.size() + 1));
        chk({tag, "_d_writes"}, 32'(nwr), 32'(exp_d.size()));
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_key_valid"}, 32'(key_valid), 32'(exp_kv));
        for (int x = 0; x < 256; x++)
            if (s_mem[x] !== 8'(ref_s[x])) mism++;
        chk({tag, "_final_s"}, 32'(mism), 32'd0);
    endtask

    // Per-cycle comparison of DUT outputs against the model expectations.
    initial begin : compare_proc
        forever begin
            @(negedge clk);
            if (!run_active) begin
                wr_idx = 0;
            end else begin
                chk("single_wren", 32'(s_wren & d_wren), 32'd0);
                if (d_wren) begin
                    if (wr_idx < exp_d.size()) begin
                        chk("d_addr", 32'(d_addr), 32'(wr_idx));
                        chk("d_wdata", 32'(d_wdata), 32'(exp_d[wr_idx]));
                    end else begin
                        chk("d_extra_write", 32'(wr_idx), 32'(exp_d.size()));
                    end
                    wr_idx++;
                end
                if (!done) chk("kv_during_run", 32'(key_valid), 32'd0);
            end
            if (done) chk("wren_in_done", 32'(s_wren | d_wren), 32'd0);
        end
    end

    initial begin : main_proc
        int lat, nwr, wr_cnt, sw;
        reset_n = 1'b0; start = 1'b0;
        ld_s = 1'b0; ld_e = 1'b0; ld_addr = 8'h00; ld_sdata = 8'h00; ld_edata = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_key_valid", 32'(key_valid), 32'd0);
        chk("rst_wren", 32'({s_wren, d_wren}), 32'd0);
        chk("rst_addrs", 32'({s_addr, e_addr, d_addr}), 32'd0);
        chk("rst_wdata", 32'({s_wdata, d_wdata}), 32'd0);
        reset_n = 1'b1;

        // Identity S: first two bytes "a " then forced abort on byte 2.
        set_identity();
        ref_e[0] = 8'h63; ref_e[1] = 8'h25; ref_e[2] = 8'h07;
        load_mem();
        model_run();
        chk("model_d0", 32'(exp_d[0]), 32'h61);
        chk("model_d1", 32'(exp_d[1]), 32'h20);
        do_run(lat, nwr);
        check_run("t1", lat, nwr);
        chk("t1_lat_lit", 32'(lat), 32'd28);
        chk("t1_d0", 32'(d_mem[0]), 32'h61);
        chk("t1_d1", 32'(d_mem[1]), 32'h20);
        chk("t1_d2", 32'(d_mem[2]), 32'h00);
        chk("t1_s2", 32'(s_mem[2]), 32'h03);
        chk("t1_s3", 32'(s_mem[3]), 32'h05);
        chk("t1_s5", 32'(s_mem[5]), 32'h02);
        end_run();

        // Identity S, E[0]=0: plaintext 0x02 is illegal at once.
        set_identity();
        load_mem();
        model_run();
        do_run(lat, nwr);
        check_run("t2", lat, nwr);
        chk("t2_lat_lit", 32'(lat), 32'd10);
        chk("t2_writes_lit", 32'(nwr), 32'd1);
        chk("t2_d0", 32'(d_mem[0]), 32'h02);
        chk("t2_kv_lit", 32'(key_valid), 32'd0);
        end_run();

        // Index wrap: j and the f address both wrap past 0xFF.
        set_identity();
        ref_s[1] = 8'hFF; ref_s[255] = 8'h01;
        ref_e[0] = 8'h61; ref_e[1] = 8'h00;
        load_mem();
        model_run();
        do_run(lat, nwr);
        check_run("t3", lat, nwr);
        chk("t3_lat_lit", 32'(lat), 32'd19);
        chk("t3_d0", 32'(d_mem[0]), 32'h61);
        chk("t3_d1", 32'(d_mem[1]), 32'h03);
        chk("t3_sff", 32'(s_mem[255]), 32'hFF);
        chk("t3_s1", 32'(s_mem[1]), 32'h02);
        chk("t3_s2", 32'(s_mem[2]), 32'h01);
        end_run();

        // Full legal pass, then hold start high in DONE, then rerun.
        rand_perm();
        gen_legal_e();
        load_mem();
        model_run();
        chk("t4_model_kv", 32'(exp_kv), 32'd1);
        do_run(lat, nwr);
        check_run("t4", lat, nwr);
        chk("t4_lat_lit", 32'(lat), 32'd289);
        wr_cnt = 0;
        repeat (50) begin
            @(negedge clk);
            chk("hold_done", 32'(done), 32'd1);
            if (s_wren || d_wren) wr_cnt++;
        end
        chk("hold_no_writes", 32'(wr_cnt), 32'd0);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_after_drop", 32'(done), 32'd0);
        model_run();
        do_run(lat, nwr);
        check_run("t4_rerun", lat, nwr);
        end_run();

        // Reset asserted during WRITE_J of byte 3.
        rand_perm();
        gen_legal_e();
        load_mem();
        model_run();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        run_active = 1'b1;
        sw = 0;
        for (int c = 0; c < 200 && sw < 8; c++) begin
            @(negedge clk);
            if (s_wren) sw++;
        end
        chk("t5_reached_write_j", 32'(sw), 32'd8);
        run_active = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_async_wren", 32'({s_wren, d_wren}), 32'd0);
        chk("t5_async_done", 32'(done), 32'd0);
        chk("t5_async_kv", 32'(key_valid), 32'd0);
        chk("t5_async_saddr", 32'(s_addr), 32'd0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        rand_perm();
        gen_legal_e();
        load_mem();
        model_run();
        do_run(lat, nwr);
        check_run("t5_after", lat, nwr);
        end_run();

        // Random permutations with random ciphertext.
        for (int r = 0; r < 3; r++) begin
            rand_perm();
            for (int k = 0; k < MSG_LEN; k++) ref_e[k] = int'($urandom_range(0, 255));
            load_mem();
            model_run();
            do_run(lat, nwr);
            check_run("t6_rand", lat, nwr);
            end_run();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
